// File: rtl/wb_commit_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_stage_if
// Brief    : MEM -> WB handshake: valid, allowin back-pressure and the bus.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_commit_stage_if;
    // The width is the sum of the bus fields (pc down to csr_re).
    localparam int c_bus_w = 188;

    logic                  ms_to_ws_valid;
    logic                  ws_allowin;
    logic [c_bus_w-1:0]    ms_to_ws_bus;

    modport master (
        output ms_to_ws_valid,
        output ms_to_ws_bus,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid,
        input  ms_to_ws_bus,
        output ws_allowin
    );
endinterface
`default_nettype wire

// File: rtl/wb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_stage
// Brief    : Write-back stage: exception arbitration, ERTN, CSR/RF commit.
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit_stage (
    input  wire          clk,
    input  wire          resetn,
    wb_commit_stage_if.slave ms_ws,
    input  wire          has_int,
    input  wire  [31:0]  csr_eentry_pc,
    input  wire  [31:0]  csr_eertn_pc,
    output logic [5:0]   exc,
    output logic         ertn_flush,
    output logic         csr_we,
    output logic [13:0]  csr_wr_num,
    output logic [31:0]  csr_wr_mask,
    output logic [31:0]  csr_wr_value,
    output logic [31:0]  wb_pc,
    output logic [31:0]  wb_fault_vaddr,
    output logic         ws_flush,
    output logic [31:0]  ws_flush_pc,
    output logic         rf_we,
    output logic [4:0]   rf_waddr,
    output logic [31:0]  rf_wdata,
    output logic [31:0]  debug_wb_pc,
    output logic [3:0]   debug_wb_rf_we,
    output logic [4:0]   debug_wb_rf_wnum,
    output logic [31:0]  debug_wb_rf_wdata,
    output logic [31:0]  retire_cnt
);

    localparam int c_bus_w = 188;

    localparam logic [5:0] c_exc_none = 6'b000000;
    localparam logic [5:0] c_exc_int  = 6'b100000;
    localparam logic [5:0] c_exc_adef = 6'b010000;
    localparam logic [5:0] c_exc_ale  = 6'b001000;
    localparam logic [5:0] c_exc_brk  = 6'b000100;
    localparam logic [5:0] c_exc_ine  = 6'b000010;
    localparam logic [5:0] c_exc_sys  = 6'b000001;

    logic                 r_ws_valid;
    logic [c_bus_w-1:0]   r_ws_bus;
    logic [31:0]          r_retire_cnt;

    logic                 w_ws_ready_go;
    logic                 w_ws_allowin;
    logic                 w_int_tag;
    logic [5:0]           w_exc;
    logic                 w_ex_commit;
    logic                 w_ertn_flush;
    logic                 w_ws_flush;
    logic                 w_rf_we;

    logic [31:0]          w_pc;
    logic [31:0]          w_fault_vaddr;
    logic [4:0]           w_exc5;
    logic                 w_is_ertn;
    logic                 w_bus_csr_we;
    logic [13:0]          w_csr_num;
    logic [31:0]          w_csr_wmask;
    logic [31:0]          w_csr_wvalue;
    logic                 w_bus_rf_we;
    logic [4:0]           w_rf_waddr;
    logic [31:0]          w_rf_wdata;
    logic                 w_unused_csr_re;

    assign w_pc            = r_ws_bus[187:156];
    assign w_fault_vaddr   = r_ws_bus[155:124];
    assign w_exc5          = r_ws_bus[123:119];
    assign w_is_ertn       = r_ws_bus[118];
    assign w_bus_csr_we    = r_ws_bus[117];
    assign w_csr_num       = r_ws_bus[116:103];
    assign w_csr_wmask     = r_ws_bus[102:71];
    assign w_csr_wvalue    = r_ws_bus[70:39];
    assign w_bus_rf_we     = r_ws_bus[38];
    assign w_rf_waddr      = r_ws_bus[37:33];
    assign w_rf_wdata      = r_ws_bus[32:1];
    // csr_re only matters to earlier stages; WB carries it through untouched.
    assign w_unused_csr_re = &{1'b0, r_ws_bus[0]};

    assign w_ws_ready_go = 1'b1;
    assign w_ws_allowin  = (~r_ws_valid | w_ws_ready_go) & ~w_ws_flush;
    assign w_int_tag     = r_ws_valid & has_int;

    // Priority: INT, ADEF, INE, SYS, BRK, ALE (exc5 = {ADEF,ALE,BRK,INE,SYS}).
    always_comb begin
        w_exc = c_exc_none;
        if (r_ws_valid) begin
            if (w_int_tag)      w_exc = c_exc_int;
            else if (w_exc5[4]) w_exc = c_exc_adef;
            else if (w_exc5[1]) w_exc = c_exc_ine;
            else if (w_exc5[0]) w_exc = c_exc_sys;
            else if (w_exc5[2]) w_exc = c_exc_brk;
            else if (w_exc5[3]) w_exc = c_exc_ale;
        end
    end

    assign w_ex_commit  = r_ws_valid & (|w_exc);
    assign w_ertn_flush = r_ws_valid & w_is_ertn & ~w_ex_commit;
    assign w_ws_flush   = w_ex_commit | w_ertn_flush;
    assign w_rf_we      = r_ws_valid & w_bus_rf_we & ~w_ex_commit & (w_rf_waddr != 5'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ws_valid <= 1'b0;
        end else if (w_ws_flush) begin
            // The instruction offered behind a flushing one is younger: drop it.
            r_ws_valid <= 1'b0;
        end else if (w_ws_allowin) begin
            r_ws_valid <= ms_ws.ms_to_ws_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ws_bus <= '0;
        end else if (w_ws_allowin && ms_ws.ms_to_ws_valid) begin
            r_ws_bus <= ms_ws.ms_to_ws_bus;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_retire_cnt <= 32'd0;
        end else if (r_ws_valid && !w_ex_commit) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign ms_ws.ws_allowin = w_ws_allowin;

    assign exc            = w_exc;
    assign ertn_flush     = w_ertn_flush;
    assign ws_flush       = w_ws_flush;
    assign ws_flush_pc    = w_ex_commit  ? csr_eentry_pc :
                            w_ertn_flush ? csr_eertn_pc  : 32'd0;

    assign csr_we         = r_ws_valid & w_bus_csr_we & ~w_ex_commit;
    assign csr_wr_num     = w_csr_num;
    assign csr_wr_mask    = w_csr_wmask;
    assign csr_wr_value   = w_csr_wvalue;

    assign rf_we          = w_rf_we;
    assign rf_waddr       = w_rf_waddr;
    assign rf_wdata       = w_rf_wdata;

    assign wb_pc          = w_pc;
    assign wb_fault_vaddr = w_fault_vaddr;

    assign debug_wb_pc       = w_pc;
    assign debug_wb_rf_we    = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = w_rf_waddr;
    assign debug_wb_rf_wdata = w_rf_wdata;

    assign retire_cnt     = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit_stage
// Brief    : Randomized and directed bench for wb_commit_stage with a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_commit_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] fault_vaddr;
        logic [4:0]  exc5;
        logic        is_ertn;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        csr_re;
    } ins_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        has_int;
    logic [31:0] csr_eentry_pc;
    logic [31:0] csr_eertn_pc;
    logic [5:0]  exc;
    logic        ertn_flush;
    logic        csr_we;
    logic [13:0] csr_wr_num;
    logic [31:0] csr_wr_mask;
    logic [31:0] csr_wr_value;
    logic [31:0] wb_pc;
    logic [31:0] wb_fault_vaddr;
    logic        ws_flush;
    logic [31:0] ws_flush_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the instruction held in WB and the retire count.
    bit          m_valid;
    ins_t        m_ins;
    logic [31:0] m_cnt;
    bit          e_flush;
    bit          e_ex;

    wb_commit_stage_if ms_ws ();

    always #5 clk = ~clk;

    wb_commit_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_ws             (ms_ws.slave),
        .has_int           (has_int),
        .csr_eentry_pc     (csr_eentry_pc),
        .csr_eertn_pc      (csr_eertn_pc),
        .exc               (exc),
        .ertn_flush        (ertn_flush),
        .csr_we            (csr_we),
        .csr_wr_num        (csr_wr_num),
        .csr_wr_mask       (csr_wr_mask),
        .csr_wr_value      (csr_wr_value),
        .wb_pc             (wb_pc),
        .wb_fault_vaddr    (wb_fault_vaddr),
        .ws_flush          (ws_flush),
        .ws_flush_pc       (ws_flush_pc),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .retire_cnt        (retire_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Walk a priority table; the first pending cause wins.
    function automatic logic [5:0] model_exc(input bit v, input ins_t i, input bit hi);
        bit         pend [6];
        logic [5:0] code [6];
        pend = '{hi, i.exc5[4], i.exc5[1], i.exc5[0], i.exc5[2], i.exc5[3]};
        code = '{6'b100000, 6'b010000, 6'b000010, 6'b000001, 6'b000100, 6'b001000};
        if (!v) return 6'd0;
        for (int k = 0; k < 6; k++)
            if (pend[k]) return code[k];
        return 6'd0;
    endfunction

    task automatic check_outputs();
        logic [5:0]  e_exc;
        bit          e_ertn;
        bit          e_rfwe;
        logic [31:0] e_fpc;
        e_exc   = model_exc(m_valid, m_ins, has_int);
        e_ex    = (e_exc != 6'd0);
        e_ertn  = m_valid && m_ins.is_ertn && !e_ex;
        e_flush = e_ex || e_ertn;
        e_fpc   = e_ex ? csr_eentry_pc : (e_ertn ? csr_eertn_pc : 32'd0);
        e_rfwe  = m_valid && m_ins.rf_we && !e_ex && (m_ins.rf_waddr != 5'd0);
        check("exc",        {58'd0, exc}, {58'd0, e_exc});
        check("ertn_flush", {63'd0, ertn_flush}, {63'd0, e_ertn});
        check("ws_flush",   {63'd0, ws_flush}, {63'd0, e_flush});
        check("flush_pc",   {32'd0, ws_flush_pc}, {32'd0, e_fpc});
        check("allowin",    {63'd0, ms_ws.ws_allowin}, {63'd0, !e_flush});
        check("csr_we",     {63'd0, csr_we}, {63'd0, m_valid && m_ins.csr_we && !e_ex});
        check("csr_port",   {18'd0, csr_wr_num, csr_wr_mask}, {18'd0, m_ins.csr_num, m_ins.csr_wmask});
        check("csr_value",  {32'd0, csr_wr_value}, {32'd0, m_ins.csr_wvalue});
        check("rf_we",      {63'd0, rf_we}, {63'd0, e_rfwe});
        check("rf_port",    {27'd0, rf_waddr, rf_wdata}, {27'd0, m_ins.rf_waddr, m_ins.rf_wdata});
        check("wb_pc_va",   {wb_pc, wb_fault_vaddr}, {m_ins.pc, m_ins.fault_vaddr});
        check("dbg_we_num", {55'd0, debug_wb_rf_we, debug_wb_rf_wnum}, {55'd0, {4{e_rfwe}}, m_ins.rf_waddr});
        check("dbg_pc_data", {debug_wb_pc, debug_wb_rf_wdata}, {m_ins.pc, m_ins.rf_wdata});
        check("retire_cnt", {32'd0, retire_cnt}, {32'd0, m_cnt});
    endtask

    // Called at a falling edge: drive, check, advance model over the rising edge.
    task automatic cycle(input bit v, input ins_t ins, input bit hi);
        ms_ws.ms_to_ws_valid = v;
        ms_ws.ms_to_ws_bus   = ins;
        has_int              = hi;
        #1;
        check_outputs();
        @(posedge clk);
        if (m_valid && !e_ex) m_cnt = m_cnt + 32'd1;
        if (e_flush) begin
            m_valid = 1'b0;
        end else begin
            m_valid = v;
            if (v) m_ins = ins;
        end
        @(negedge clk);
    endtask

    function automatic ins_t rand_ins();
        ins_t i;
        i.pc          = $urandom;
        i.fault_vaddr = $urandom;
        i.exc5        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
        i.is_ertn     = ($urandom_range(0, 5) == 0);
        i.csr_we      = 1'($urandom);
        i.csr_num     = 14'($urandom);
        i.csr_wmask   = $urandom;
        i.csr_wvalue  = $urandom;
        i.rf_we       = 1'($urandom);
        i.rf_waddr    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        i.rf_wdata    = $urandom;
        i.csr_re      = 1'($urandom);
        return i;
    endfunction

    function automatic ins_t mk(input logic [31:0] pc, input logic [4:0] exc5, input bit ertn,
                                input bit cwe, input bit rwe, input logic [4:0] wa,
                                input logic [31:0] wd);
        ins_t i;
        i             = '0;
        i.pc          = pc;
        i.fault_vaddr = pc ^ 32'h0000_0F0F;
        i.exc5        = exc5;
        i.is_ertn     = ertn;
        i.csr_we      = cwe;
        i.csr_num     = 14'h0006;
        i.csr_wmask   = 32'hFFFF_0000;
        i.csr_wvalue  = 32'hA5A5_5A5A;
        i.rf_we       = rwe;
        i.rf_waddr    = wa;
        i.rf_wdata    = wd;
        return i;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_ins   = '0;
        m_cnt   = 32'd0;
    endtask

    initial begin
        ins_t idle;
        idle                 = '0;
        resetn               = 1'b0;
        has_int              = 1'b0;
        csr_eentry_pc        = 32'h1C00_8000;
        csr_eertn_pc         = 32'h1C00_0100;
        ms_ws.ms_to_ws_valid = 1'b0;
        ms_ws.ms_to_ws_bus   = '0;
        model_reset();

        #2;
        check_outputs();
        check("rst_allowin", {63'd0, ms_ws.ws_allowin}, 64'd1);
        check("rst_cnt",     {32'd0, retire_cnt}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Plain ALU result reaches the register file and trace port.
        cycle(1'b1, mk(32'h1C00_0000, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678), 1'b0);
        #1;
        check("add_rf_we",   {63'd0, rf_we}, 64'd1);
        check("add_dbg_we",  {60'd0, debug_wb_rf_we}, 64'hF);
        check("add_cnt0",    {32'd0, retire_cnt}, 64'd0);

        // SYSCALL flushes; the instruction offered behind it is discarded.
        cycle(1'b1, mk(32'h1C00_0004, 5'b00001, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0BAD_0BAD), 1'b0);
        #1;
        check("add_cnt1",    {32'd0, retire_cnt}, 64'd1);
        check("sys_exc",     {58'd0, exc}, 64'b000001);
        check("sys_flush",   {32'd0, ws_flush_pc}, 64'h1C00_8000);
        check("sys_rf_we",   {63'd0, rf_we}, 64'd0);
        cycle(1'b1, mk(32'h1C00_0008, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF), 1'b0);
        #1;
        check("flushed_rf",  {63'd0, rf_we}, 64'd0);
        check("flushed_cnt", {32'd0, retire_cnt}, 64'd1);

        // Interrupt beats ALE and blocks the CSR write.
        cycle(1'b1, mk(32'h1C00_0010, 5'b01000, 1'b0, 1'b1, 1'b1, 5'd9, 32'h1), 1'b1);
        #1;
        check("int_exc",     {58'd0, exc}, 64'b100000);
        check("int_csr_we",  {63'd0, csr_we}, 64'd0);
        cycle(1'b0, idle, 1'b0);
        #1;
        check("int_cnt",     {32'd0, retire_cnt}, 64'd1);

        // ERTN redirects to the return address and counts as retired.
        csr_eertn_pc = 32'h1C00_0100;
        cycle(1'b1, mk(32'h1C00_0020, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0), 1'b0);
        #1;
        check("ertn_flush",  {63'd0, ertn_flush}, 64'd1);
        check("ertn_pc",     {32'd0, ws_flush_pc}, 64'h1C00_0100);
        check("ertn_exc",    {58'd0, exc}, 64'd0);
        cycle(1'b0, idle, 1'b0);
        #1;
        check("ertn_cnt",    {32'd0, retire_cnt}, 64'd2);

        // Writes to r0 are dropped; counter wraps at the top.
        cycle(1'b1, mk(32'h1C00_0030, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h5555_AAAA), 1'b0);
        #1;
        check("r0_rf_we",    {63'd0, rf_we}, 64'd0);
        check("r0_dbg_we",   {60'd0, debug_wb_rf_we}, 64'd0);
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        m_cnt = 32'hFFFF_FFFF;
        cycle(1'b0, idle, 1'b0);
        #1;
        check("cnt_wrap",    {32'd0, retire_cnt}, 64'd0);

        // Reset pulsed in the middle of a flushing cycle.
        cycle(1'b1, mk(32'h1C00_0040, 5'b00100, 1'b0, 1'b1, 1'b1, 5'd4, 32'h7), 1'b0);
        #1;
        check("brk_flush",   {63'd0, ws_flush}, 64'd1);
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("mid_rst_flush", {63'd0, ws_flush}, 64'd0);
        check("mid_rst_allow", {63'd0, ms_ws.ws_allowin}, 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        cycle(1'b1, mk(32'h1C00_0050, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h6), 1'b0);
        #1;
        check("post_rst_rf", {63'd0, rf_we}, 64'd1);

        for (int n = 0; n < 400; n++) begin
            csr_eentry_pc = $urandom;
            csr_eertn_pc  = $urandom;
            cycle(($urandom_range(0, 3) != 0), rand_ins(), ($urandom_range(0, 7) == 0));
        end
        #1;
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
